// File: rtl/sn_pair_gen.sv
// Stochastic-number pair generator: emits exact, uncorrelated unary bitstreams
// for two N-bit operands by clock-dividing two N-bit counters (i fast, j slow).
module sn_pair_gen #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] x_in,
  input  logic [N-1:0] y_in,
  output logic         busy,
  output logic         SN_X,
  output logic         SN_Y,
  output logic         sn_valid,
  output logic         last,
  output logic         done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [N-1:0] C_ONE = N'(1'b1);
  localparam logic [N-1:0] C_MAX = {N{1'b1}};

  state_t       r_state;
  state_t       w_state_nxt;
  logic [N-1:0] r_i, r_j, r_x, r_y;
  logic [N-1:0] w_i_nxt, w_j_nxt, w_x_nxt, w_y_nxt;
  logic         r_busy, r_sn_x, r_sn_y, r_sn_valid, r_last, r_done;
  logic         w_busy_nxt, w_sn_x_nxt, w_sn_y_nxt, w_sn_valid_nxt, w_last_nxt, w_done_nxt;

  // Next-state, counter and output-bit decode; outputs are registered below.
  always_comb begin
    w_state_nxt    = r_state;
    w_i_nxt        = r_i;
    w_j_nxt        = r_j;
    w_x_nxt        = r_x;
    w_y_nxt        = r_y;
    w_busy_nxt     = 1'b0;
    w_sn_x_nxt     = 1'b0;
    w_sn_y_nxt     = 1'b0;
    w_sn_valid_nxt = 1'b0;
    w_last_nxt     = 1'b0;
    w_done_nxt     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_RUN;
          w_x_nxt     = x_in;
          w_y_nxt     = y_in;
          w_i_nxt     = '0;
          w_j_nxt     = '0;
          w_busy_nxt  = 1'b1;
        end else begin
          w_busy_nxt  = 1'b0;
        end
      end
      S_RUN: begin
        w_busy_nxt     = 1'b1;
        w_sn_valid_nxt = 1'b1;
        w_sn_x_nxt     = (r_i < r_x);
        w_sn_y_nxt     = (r_j < r_y);
        w_i_nxt        = r_i + C_ONE;
        // j advances only on i wrap, which decorrelates the two streams
        if (r_i == C_MAX) begin
          w_j_nxt = r_j + C_ONE;
          if (r_j == C_MAX) begin
            w_last_nxt  = 1'b1;
            w_state_nxt = S_DONE;
          end else begin
            w_last_nxt  = 1'b0;
          end
        end else begin
          w_j_nxt = r_j;
        end
      end
      S_DONE: begin
        w_busy_nxt  = 1'b1;
        w_done_nxt  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Counters, latched operands and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_i        <= '0;
      r_j        <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_busy     <= 1'b0;
      r_sn_x     <= 1'b0;
      r_sn_y     <= 1'b0;
      r_sn_valid <= 1'b0;
      r_last     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_i        <= w_i_nxt;
      r_j        <= w_j_nxt;
      r_x        <= w_x_nxt;
      r_y        <= w_y_nxt;
      r_busy     <= w_busy_nxt;
      r_sn_x     <= w_sn_x_nxt;
      r_sn_y     <= w_sn_y_nxt;
      r_sn_valid <= w_sn_valid_nxt;
      r_last     <= w_last_nxt;
      r_done     <= w_done_nxt;
    end
  end

  assign busy     = r_busy;
  assign SN_X     = r_sn_x;
  assign SN_Y     = r_sn_y;
  assign sn_valid = r_sn_valid;
  assign last     = r_last;
  assign done     = r_done;

endmodule
